// File: rtl/eva_mem_arb_if.sv
// rtl/eva_mem_arb_if.sv - requester channels and shared memory port of the arbiter
interface eva_mem_arb_if #(
    parameter int NREQ     = 4,
    parameter int WIDTH    = 32,
    parameter int MASKBITS = 1
);
    logic [NREQ-1:0]          req_valid;
    logic [NREQ-1:0]          req_ready;
    logic [NREQ*MASKBITS-1:0] req_we;
    logic [NREQ*32-1:0]       req_addr;
    logic [NREQ*WIDTH-1:0]    req_wdata;
    logic [NREQ-1:0]          rsp_valid;
    logic [WIDTH-1:0]         rsp_data;
    logic                     mem_rd;
    logic [MASKBITS-1:0]      mem_we;
    logic [31:0]              mem_addr;
    logic [WIDTH-1:0]         mem_wdata;
    logic [WIDTH-1:0]         mem_rdata;

    // Arbiter side.
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, mem_rdata,
        output req_ready, rsp_valid, rsp_data, mem_rd, mem_we, mem_addr, mem_wdata
    );

    // Requester and memory-model side.
    modport master (
        output req_valid, req_we, req_addr, req_wdata, mem_rdata,
        input  req_ready, rsp_valid, rsp_data, mem_rd, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/eva_mem_arb.sv
// rtl/eva_mem_arb.sv - round-robin arbiter sharing one memory port with tagged read return
module eva_mem_arb #(
    parameter int NREQ     = 4,
    parameter int WIDTH    = 32,
    parameter int MASKBITS = 1,
    parameter int RD_LAT   = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         arb_en,
    output logic         idle,
    eva_mem_arb_if.slave bus
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [IDW-1:0]      rr_q, rr_d;
    logic                gnt_vld;
    logic [IDW-1:0]      gnt_id;
    logic [MASKBITS-1:0] gnt_we;
    logic [31:0]         gnt_addr;
    logic [WIDTH-1:0]    gnt_wdata;
    logic                gnt_rd;

    logic                mem_rd_q;
    logic [MASKBITS-1:0] mem_we_q;
    logic [31:0]         mem_addr_q;
    logic [WIDTH-1:0]    mem_wdata_q;
    logic [RD_LAT:0]     tag_vld_q;
    logic [IDW-1:0]      tag_id_q [0:RD_LAT];
    logic [NREQ-1:0]     rsp_valid_q;
    logic [WIDTH-1:0]    rsp_data_q;

    // Descending scan so the requester closest to the pointer wins the final overwrite.
    always_comb begin
        int idx;
        idx     = 0;
        gnt_vld = 1'b0;
        gnt_id  = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = (int'(rr_q) + k) % NREQ;
            if (arb_en && bus.req_valid[idx]) begin
                gnt_vld = 1'b1;
                gnt_id  = IDW'(idx);
            end
        end
    end

    assign gnt_we    = bus.req_we[int'(gnt_id) * MASKBITS +: MASKBITS];
    assign gnt_addr  = bus.req_addr[int'(gnt_id) * 32 +: 32];
    assign gnt_wdata = bus.req_wdata[int'(gnt_id) * WIDTH +: WIDTH];
    assign gnt_rd    = (gnt_we == '0);

    always_comb begin
        rr_d = rr_q;
        if (gnt_vld) begin
            rr_d = (int'(gnt_id) == NREQ - 1) ? '0 : gnt_id + IDW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q        <= '0;
            mem_rd_q    <= 1'b0;
            mem_we_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            tag_vld_q   <= '0;
            for (int i = 0; i <= RD_LAT; i++) begin
                tag_id_q[i] <= '0;
            end
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            rr_q     <= rr_d;
            mem_rd_q <= gnt_vld & gnt_rd;
            mem_we_q <= gnt_vld ? gnt_we : '0;
            if (gnt_vld) begin
                mem_addr_q  <= gnt_addr;
                mem_wdata_q <= gnt_wdata;
            end
            // Stage 0 mirrors the command register; the last stage lines up with mem_rdata.
            tag_vld_q[0] <= gnt_vld & gnt_rd;
            tag_id_q[0]  <= gnt_id;
            for (int i = 1; i <= RD_LAT; i++) begin
                tag_vld_q[i] <= tag_vld_q[i-1];
                tag_id_q[i]  <= tag_id_q[i-1];
            end
            rsp_valid_q <= tag_vld_q[RD_LAT] ? (NREQ'(1) << tag_id_q[RD_LAT]) : '0;
            if (tag_vld_q[RD_LAT]) begin
                rsp_data_q <= bus.mem_rdata;
            end
        end
    end

    assign bus.req_ready = gnt_vld ? (NREQ'(1) << gnt_id) : '0;
    assign bus.mem_rd    = mem_rd_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;

    assign idle = !gnt_vld && (tag_vld_q == '0) && !mem_rd_q && (mem_we_q == '0);
endmodule
